// File: rtl/traffic_fsm_pkg.sv
// Shared encodings for the traffic light sequencer: interval addresses,
// state codes and the lamp pattern driven in each state.
package traffic_fsm_pkg;

  localparam logic [1:0] INT_BASE = 2'd0;
  localparam logic [1:0] INT_EXT  = 2'd1;
  localparam logic [1:0] INT_YEL  = 2'd2;

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    WALK = 3'd3,
    SG1  = 3'd4,
    SG2  = 3'd5,
    SY   = 3'd6
  } state_t;

  // Lamp order {Rm,Ym,Gm,Rs,Ys,Gs,W}
  localparam logic [6:0] LT_MG1  = 7'b0011000;
  localparam logic [6:0] LT_MG2  = 7'b0011000;
  localparam logic [6:0] LT_MY   = 7'b0101000;
  localparam logic [6:0] LT_WALK = 7'b1001001;
  localparam logic [6:0] LT_SG1  = 7'b1000010;
  localparam logic [6:0] LT_SG2  = 7'b1000010;
  localparam logic [6:0] LT_SY   = 7'b1000100;

  function automatic logic [6:0] light_pattern(state_t s);
    case (s)
      MG1:     return LT_MG1;
      MG2:     return LT_MG2;
      MY:      return LT_MY;
      WALK:    return LT_WALK;
      SG1:     return LT_SG1;
      SG2:     return LT_SG2;
      SY:      return LT_SY;
      default: return LT_MG1;
    endcase
  endfunction

endpackage

// File: rtl/traffic_fsm.sv
// Light-sequencing FSM: steps through the main/side/walk phases on timer
// expiry, selects the next interval and pulses start_timer on each entry.
module traffic_fsm
  import traffic_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       sensor_sync,
  input  logic       WR,
  input  logic       prog_sync,
  input  logic       expired,
  output logic [1:0] interval,
  output logic       start_timer,
  output logic       WR_reset,
  output logic       Rm,
  output logic       Ym,
  output logic       Gm,
  output logic       Rs,
  output logic       Ys,
  output logic       Gs,
  output logic       W
);

  state_t     state_q, state_d;
  logic       entry_q, entry_d;
  logic       take;
  logic       advance;
  logic [1:0] interval_d;
  logic       start_d;
  logic       wr_reset_d;
  logic [6:0] lights_q, lights_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q     <= MG1;
      entry_q     <= 1'b1;
      interval    <= INT_BASE;
      lights_q    <= LT_MG1;
      start_timer <= 1'b0;
      WR_reset    <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      interval    <= interval_d;
      lights_q    <= lights_d;
      start_timer <= start_d;
      WR_reset    <= wr_reset_d;
    end
  end

  // Expiry only counts once the current interval has actually been loaded,
  // i.e. not in the start_timer cycle nor while a deferred start is pending.
  assign advance = expired && !start_timer && !entry_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    take    = 1'b0;
    if (prog_sync) begin
      state_d = MG1;
      entry_d = 1'b1;
    end else begin
      case (state_q)
        MG1:  if (advance) begin state_d = MG2;                    take = 1'b1; end
        MG2:  if (advance) begin state_d = MY;                     take = 1'b1; end
        MY:   if (advance) begin state_d = WR ? WALK : SG1;        take = 1'b1; end
        WALK: if (advance) begin state_d = SG1;                    take = 1'b1; end
        SG1:  if (advance) begin state_d = sensor_sync ? SG2 : SY; take = 1'b1; end
        SG2:  if (advance) begin state_d = SY;                     take = 1'b1; end
        SY:   if (advance) begin state_d = MG1;                    take = 1'b1; end
        default: begin
          state_d = MG1;
          take    = 1'b1;
        end
      endcase
    end
  end

  // Output decode for the registered outputs, keyed on the state being entered
  always_comb begin
    lights_d   = light_pattern(state_d);
    interval_d = interval;
    start_d    = 1'b0;
    wr_reset_d = 1'b0;
    if (prog_sync) begin
      interval_d = INT_BASE;
    end else begin
      start_d = take || entry_q;
      if (take) begin
        case (state_d)
          MG1:     interval_d = INT_BASE;
          MG2:     interval_d = sensor_sync ? INT_EXT : INT_BASE;
          MY:      interval_d = INT_YEL;
          WALK:    interval_d = INT_EXT;
          SG1:     interval_d = INT_BASE;
          SG2:     interval_d = INT_EXT;
          SY:      interval_d = INT_YEL;
          default: interval_d = INT_BASE;
        endcase
        wr_reset_d = (state_d == WALK);
      end
    end
  end

  assign {Rm, Ym, Gm, Rs, Ys, Gs, W} = lights_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Directed bench for traffic_fsm with a timer stub (BASE=6, EXT=3, YEL=2
// cycles from start_timer to expired) and per-cycle lamp invariant checks.
module tb_traffic_fsm;

  localparam logic [6:0] P_MG   = 7'b0011000;
  localparam logic [6:0] P_MY   = 7'b0101000;
  localparam logic [6:0] P_WALK = 7'b1001001;
  localparam logic [6:0] P_SG   = 7'b1000010;
  localparam logic [6:0] P_SY   = 7'b1000100;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       sensor_sync = 1'b0;
  logic       WR = 1'b0;
  logic       prog_sync = 1'b0;
  logic       expired;
  logic [1:0] interval;
  logic       start_timer;
  logic       WR_reset;
  logic       Rm, Ym, Gm, Rs, Ys, Gs, W;

  logic       stub_exp = 1'b0;
  logic       force_exp = 1'b0;
  int         cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_fsm dut (
    .clk         (clk),
    .sys_reset   (sys_reset),
    .sensor_sync (sensor_sync),
    .WR          (WR),
    .prog_sync   (prog_sync),
    .expired     (expired),
    .interval    (interval),
    .start_timer (start_timer),
    .WR_reset    (WR_reset),
    .Rm          (Rm),
    .Ym          (Ym),
    .Gm          (Gm),
    .Rs          (Rs),
    .Ys          (Ys),
    .Gs          (Gs),
    .W           (W)
  );

  always #5 clk = ~clk;

  assign expired = stub_exp | force_exp;

  // Timer stub: expired is raised N cycles after the start_timer cycle
  always @(negedge clk) begin
    stub_exp = 1'b0;
    if (sys_reset) begin
      cnt = 0;
    end else if (start_timer) begin
      case (interval)
        2'd0:    cnt = 6;
        2'd1:    cnt = 3;
        default: cnt = 2;
      endcase
    end else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) stub_exp = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("inv_main_onehot", 8'($countones({Rm, Ym, Gm})), 8'd1);
    check("inv_side_onehot", 8'($countones({Rs, Ys, Gs})), 8'd1);
    check("inv_two_greens",  {7'b0, Gm & Gs}, 8'd0);
    check("inv_walk_red",    {7'b0, W & ~(Rm & Rs)}, 8'd0);
  endtask

  task automatic check_lamps(input string tag, input logic [6:0] exp);
    check(tag, {1'b0, Rm, Ym, Gm, Rs, Ys, Gs, W}, {1'b0, exp});
  endtask

  // Tick until the next start_timer pulse (bounded) and check the entered state
  task automatic next_entry(input string tag, input int gap, input logic [6:0] lts,
                            input logic [1:0] iv, input logic wrr);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (start_timer !== 1'b1 && n < 40);
    check({tag, "_gap"}, 8'(n), 8'(gap));
    check_lamps({tag, "_lamps"}, lts);
    check({tag, "_interval"}, {6'b0, interval}, {6'b0, iv});
    check({tag, "_wr_reset"}, {7'b0, WR_reset}, {7'b0, wrr});
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_lamps("rst_lamps", P_MG);
    check("rst_start", {7'b0, start_timer}, 8'd0);
    check("rst_wr_reset", {7'b0, WR_reset}, 8'd0);
    check("rst_interval", {6'b0, interval}, 8'd0);
    sys_reset = 1'b0;

    // Idle cycle: start pulses at 1, 8, 15, 18, 25, 28
    next_entry("mg1_first", 1, P_MG, 2'd0, 1'b0);
    next_entry("mg2_base",  7, P_MG, 2'd0, 1'b0);
    next_entry("my",        7, P_MY, 2'd2, 1'b0);
    next_entry("sg1",       3, P_SG, 2'd0, 1'b0);
    next_entry("sy",        7, P_SY, 2'd2, 1'b0);
    next_entry("mg1_again", 3, P_MG, 2'd0, 1'b0);

    // Side-street car present throughout
    sensor_sync = 1'b1;
    next_entry("mg2_ext",   7, P_MG, 2'd1, 1'b0);
    next_entry("my_s",      4, P_MY, 2'd2, 1'b0);
    next_entry("sg1_s",     3, P_SG, 2'd0, 1'b0);
    next_entry("sg2",       7, P_SG, 2'd1, 1'b0);
    next_entry("sy_s",      4, P_SY, 2'd2, 1'b0);
    next_entry("mg1_s",     3, P_MG, 2'd0, 1'b0);
    sensor_sync = 1'b0;

    // Walk request before MY expires
    WR = 1'b1;
    next_entry("mg2_w",     7, P_MG, 2'd0, 1'b0);
    next_entry("my_w",      7, P_MY, 2'd2, 1'b0);
    next_entry("walk",      3, P_WALK, 2'd1, 1'b1);
    WR = 1'b0;
    tick();
    check("walk_wr_reset_one_cycle", {7'b0, WR_reset}, 8'd0);
    check("walk_start_one_cycle", {7'b0, start_timer}, 8'd0);
    next_entry("sg1_after_walk", 3, P_SG, 2'd0, 1'b0);

    // prog_sync coincident with SG1 expiry
    for (int i = 0; i < 6; i++) tick();
    prog_sync = 1'b1;
    tick();
    prog_sync = 1'b0;
    check("prog_expired_seen", {7'b0, expired}, 8'd1);
    check_lamps("prog_lamps", P_MG);
    check("prog_interval", {6'b0, interval}, 8'd0);
    check("prog_start_low", {7'b0, start_timer}, 8'd0);
    next_entry("prog_start", 1, P_MG, 2'd0, 1'b0);

    // expired held high in the start_timer cycle is ignored
    force_exp = 1'b1;
    tick();
    force_exp = 1'b0;
    check_lamps("force_lamps", P_MG);
    check("force_start", {7'b0, start_timer}, 8'd0);
    next_entry("mg2_after_force", 6, P_MG, 2'd0, 1'b0);

    // sys_reset during WALK
    WR = 1'b1;
    next_entry("my_r",      7, P_MY, 2'd2, 1'b0);
    next_entry("walk_r",    3, P_WALK, 2'd1, 1'b1);
    WR = 1'b0;
    tick();
    sys_reset = 1'b1;
    tick();
    check_lamps("rst_walk_lamps", P_MG);
    check("rst_walk_start", {7'b0, start_timer}, 8'd0);
    check("rst_walk_wr_reset", {7'b0, WR_reset}, 8'd0);
    check("rst_walk_interval", {6'b0, interval}, 8'd0);
    tick();
    check("rst_hold_start", {7'b0, start_timer}, 8'd0);
    sys_reset = 1'b0;
    next_entry("rst_release", 1, P_MG, 2'd0, 1'b0);
    next_entry("mg2_final",   7, P_MG, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
